// File: rtl/dm_store_unit.sv
// MEM-stage data memory: SB/SH/SW byte-lane writes, raw word reads for the
// load extender, address-error detection, and a post-reset zeroing sweep.
module dm_store_unit #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Ins,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        Flush,
  output logic [31:0] RData,
  output logic [3:0]  ByteEn,
  output logic        Ready,
  output logic        ExcAdEL,
  output logic        ExcAdES
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  logic [31:0]           r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;

  logic [5:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_misaligned;
  logic                  w_range_err;
  logic                  w_exc_load;
  logic                  w_exc_store;
  logic [3:0]            w_st_be;
  logic [31:0]           w_st_data;
  logic [3:0]            w_byte_en;

  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [3:0]            w_wr_be;
  logic [31:0]           w_wr_data;

  // Only the opcode field is decoded; the rest of the instruction is ignored.
  logic w_unused_ins;
  assign w_unused_ins = &{1'b0, Ins[25:0]};

  assign w_op  = Ins[31:26];
  assign w_idx = Addr[ADDR_WIDTH+1:2];

  // Opcode decode, alignment check and store lane/data steering.
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_st_be      = 4'b0000;
    w_st_data    = 32'h0000_0000;
    case (w_op)
      OP_SB: begin
        w_is_store = 1'b1;
        w_st_be    = 4'b0001 << Addr[1:0];
        w_st_data  = {4{WData[7:0]}};
      end
      OP_SH: begin
        w_is_store   = 1'b1;
        w_misaligned = Addr[0];
        w_st_be      = Addr[1] ? 4'b1100 : 4'b0011;
        w_st_data    = {2{WData[15:0]}};
      end
      OP_SW: begin
        w_is_store   = 1'b1;
        w_misaligned = |Addr[1:0];
        w_st_be      = 4'b1111;
        w_st_data    = WData;
      end
      OP_LB, OP_LBU: begin
        w_is_load = 1'b1;
      end
      OP_LH, OP_LHU: begin
        w_is_load    = 1'b1;
        w_misaligned = Addr[0];
      end
      OP_LW: begin
        w_is_load    = 1'b1;
        w_misaligned = |Addr[1:0];
      end
      default: begin
      end
    endcase
  end

  // Any address bit above the array's byte range is an error.
  assign w_range_err = (Addr >> (ADDR_WIDTH + 2)) != 32'h0000_0000;

  assign w_exc_load  = r_ready & w_is_load  & (w_misaligned | w_range_err);
  assign w_exc_store = r_ready & w_is_store & (w_misaligned | w_range_err);

  // A store commits only when running, legal and not flushed.
  assign w_byte_en = (r_ready && w_is_store && !w_exc_store && !Flush) ? w_st_be : 4'b0000;

  // Write port shared between the clear sweep and normal stores.
  always_comb begin
    w_wr_idx  = r_cnt;
    w_wr_be   = 4'b1111;
    w_wr_data = 32'h0000_0000;
    if (r_ready) begin
      w_wr_idx  = w_idx;
      w_wr_be   = w_byte_en;
      w_wr_data = w_st_data;
    end
  end

  // Byte-lane memory write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_be[i]) begin
        r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // Clear-sweep FSM next-state: one word per edge, then RUN until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    case (r_state)
      S_CLEAR: begin
        w_cnt_nxt = ADDR_WIDTH'(r_cnt + 1'b1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_RUN;
          w_ready_nxt = 1'b1;
        end
      end
      S_RUN: begin
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, sweep counter and Ready registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Read returns the pre-write word; blanked while the sweep runs.
  assign RData   = r_ready ? r_mem[w_idx] : 32'h0000_0000;
  assign ByteEn  = w_byte_en;
  assign Ready   = r_ready;
  assign ExcAdEL = w_exc_load;
  assign ExcAdES = w_exc_store;

endmodule

// File: tb/tb_dm_store_unit.sv
// Self-checking bench for dm_store_unit with a 16-word array.
module tb_dm_store_unit;

  localparam int unsigned AW = 4;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_ADD = 6'b000000;

  logic        clk;
  logic        reset;
  logic [31:0] Ins;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Flush;
  logic [31:0] RData;
  logic [3:0]  ByteEn;
  logic        Ready;
  logic        ExcAdEL;
  logic        ExcAdES;

  int n_chk;
  int n_fail;

  logic [31:0] sb_q [$];
  string       nm_q [$];
  logic [31:0] model [16];

  dm_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .Ins     (Ins),
    .Addr    (Addr),
    .WData   (WData),
    .Flush   (Flush),
    .RData   (RData),
    .ByteEn  (ByteEn),
    .Ready   (Ready),
    .ExcAdEL (ExcAdEL),
    .ExcAdES (ExcAdES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction at the falling edge and let outputs settle.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, input logic fl);
    @(negedge clk);
    Ins   = {op, 26'h2ABCDEF};
    Addr  = a;
    WData = wd;
    Flush = fl;
    #1;
  endtask

  // Count edges after release until Ready rises; track outputs seen during the sweep.
  task automatic run_sweep(output int edges, output logic leak);
    edges = 0;
    leak  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (Ready) break;
      if (RData !== 32'h0 || ByteEn !== 4'h0 || ExcAdES !== 1'b0 || ExcAdEL !== 1'b0) leak = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    string nm;
    @(negedge clk);
    reset = 1'b0;
    Ins   = {OP_SW, 26'h0};
    Addr  = 32'h0000_0002;
    WData = 32'hFFFF_FFFF;
    Flush = 1'b0;
    #1;
    sb_q.push_back(32'h0); nm_q.push_back("reset_ready");
    sb_q.push_back(32'h0); nm_q.push_back("reset_rdata");
    sb_q.push_back(32'h0); nm_q.push_back("reset_byteen");
    sb_q.push_back(32'h0); nm_q.push_back("reset_exc");
    got = {31'h0, Ready};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_clear_sweep;
    logic [31:0] got, exp;
    string nm;
    int edges;
    logic leak;
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(32'd16); nm_q.push_back("sweep_edges");
    sb_q.push_back(32'd0);  nm_q.push_back("sweep_quiet");
    run_sweep(edges, leak);
    got = 32'(edges);
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {31'h0, leak};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      drive(OP_LW, 32'(i * 4), 32'h0, 1'b0);
      sb_q.push_back(model[i]); nm_q.push_back("sweep_word_zero");
      got = RData;
      exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s[%0d]: got=%08h exp=%08h", nm, i, got, exp); end
    end
  endtask

  task automatic test_byte_merge;
    logic [31:0] got, exp;
    string nm;
    drive(OP_SW, 32'h8, 32'h1234_5678, 1'b0);
    sb_q.push_back(32'hF); nm_q.push_back("sw_byteen");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[2] = 32'h1234_5678;
    drive(OP_SB, 32'h9, 32'h0000_00AB, 1'b0);
    sb_q.push_back(32'h2);         nm_q.push_back("sb_byteen");
    sb_q.push_back(32'h1234_5678); nm_q.push_back("sb_read_old");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[2] = 32'h1234_AB78;
    drive(OP_SB, 32'hB, 32'hFFFF_FFC3, 1'b0);
    sb_q.push_back(32'h8); nm_q.push_back("sb_lane3_byteen");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[2] = 32'hC334_AB78;
    drive(OP_LW, 32'h8, 32'h0, 1'b0);
    sb_q.push_back(model[2]); nm_q.push_back("byte_merge_read");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  task automatic test_halfword;
    logic [31:0] got, exp;
    string nm;
    drive(OP_SW, 32'h4, 32'h1122_3344, 1'b0);
    model[1] = 32'h1122_3344;
    drive(OP_SH, 32'h6, 32'h0000_BEEF, 1'b0);
    sb_q.push_back(32'hC); nm_q.push_back("sh_hi_byteen");
    sb_q.push_back(32'h0); nm_q.push_back("sh_hi_exc");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {31'h0, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[1] = 32'hBEEF_3344;
    drive(OP_LW, 32'h4, 32'h0, 1'b0);
    sb_q.push_back(model[1]); nm_q.push_back("sh_hi_read");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_SH, 32'h4, 32'h1234_CAFE, 1'b0);
    sb_q.push_back(32'h3); nm_q.push_back("sh_lo_byteen");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[1] = 32'hBEEF_CAFE;
    drive(OP_LW, 32'h4, 32'h0, 1'b0);
    sb_q.push_back(model[1]); nm_q.push_back("sh_lo_read");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  task automatic test_addr_errors;
    logic [31:0] got, exp;
    string nm;
    drive(OP_LW, 32'h2, 32'h0, 1'b0);
    sb_q.push_back(32'h2); nm_q.push_back("lw_misaligned_exc");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LH, 32'h2, 32'h0, 1'b0);
    sb_q.push_back(32'h0); nm_q.push_back("lh_aligned_exc");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LB, 32'h3, 32'h0, 1'b0);
    sb_q.push_back(32'h0); nm_q.push_back("lb_odd_exc");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_SH, 32'h3, 32'hFFFF_FFFF, 1'b0);
    sb_q.push_back(32'h1); nm_q.push_back("sh_misaligned_exc");
    sb_q.push_back(32'h0); nm_q.push_back("sh_misaligned_byteen");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    sb_q.push_back(model[0]); nm_q.push_back("sh_misaligned_nowrite");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_SW, 32'h40, 32'hFFFF_FFFF, 1'b0);
    sb_q.push_back(32'h1); nm_q.push_back("sw_range_exc");
    sb_q.push_back(32'h0); nm_q.push_back("sw_range_byteen");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    sb_q.push_back(model[0]); nm_q.push_back("sw_range_nowrite");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LB, 32'h8000_0001, 32'h0, 1'b0);
    sb_q.push_back(32'h2); nm_q.push_back("lb_range_exc");
    got = {30'h0, ExcAdEL, ExcAdES};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_ADD, 32'h4000_0003, 32'hFFFF_FFFF, 1'b0);
    sb_q.push_back(32'h0); nm_q.push_back("nonmem_exc_byteen");
    got = {26'h0, ExcAdEL, ExcAdES, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  task automatic test_flush;
    logic [31:0] got, exp;
    string nm;
    drive(OP_SW, 32'hC, 32'hDEAD_BEEF, 1'b1);
    sb_q.push_back(32'h0); nm_q.push_back("flush_byteen");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_SW, 32'hC, 32'hDEAD_BEEF, 1'b0);
    sb_q.push_back(32'hF);      nm_q.push_back("noflush_byteen");
    sb_q.push_back(model[3]);   nm_q.push_back("flush_nowrite");
    got = {28'h0, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    model[3] = 32'hDEAD_BEEF;
    drive(OP_SW, 32'hD, 32'h5555_5555, 1'b1);
    sb_q.push_back(32'h10); nm_q.push_back("flush_exc_both");
    got = {27'h0, ExcAdES, ByteEn};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LW, 32'hC, 32'h0, 1'b0);
    sb_q.push_back(model[3]); nm_q.push_back("flush_then_write");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  task automatic test_reset_run;
    logic [31:0] got, exp;
    string nm;
    int edges;
    logic leak;
    drive(OP_SW, 32'h0, 32'hFFFF_FFFF, 1'b0);
    model[0] = 32'hFFFF_FFFF;
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    sb_q.push_back(model[0]); nm_q.push_back("pre_reset_read");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    sb_q.push_back(32'h0); nm_q.push_back("run_reset_ready_rdata");
    got = {Ready, RData[30:0]} | {31'h0, |RData};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(32'd16); nm_q.push_back("resweep_edges");
    sb_q.push_back(32'd0);  nm_q.push_back("resweep_quiet");
    run_sweep(edges, leak);
    got = 32'(edges);
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {31'h0, leak};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    sb_q.push_back(model[0]); nm_q.push_back("post_resweep_read");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  task automatic test_reset_mid_sweep;
    logic [31:0] got, exp;
    string nm;
    int edges;
    logic leak;
    drive(OP_SW, 32'hC, 32'hA5A5_5A5A, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    sb_q.push_back(32'h0); nm_q.push_back("mid_reset_ready");
    got = {31'h0, Ready};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(32'd16); nm_q.push_back("mid_restart_edges");
    sb_q.push_back(32'd0);  nm_q.push_back("mid_restart_quiet");
    run_sweep(edges, leak);
    got = 32'(edges);
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    got = {31'h0, leak};
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
    drive(OP_LW, 32'hC, 32'h0, 1'b0);
    sb_q.push_back(32'h0); nm_q.push_back("mid_restart_cleared");
    got = RData;
    exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_chk++; if (got !== exp) begin n_fail++; $display("FAIL %s: got=%08h exp=%08h", nm, got, exp); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    Ins    = 32'h0;
    Addr   = 32'h0;
    WData  = 32'h0;
    Flush  = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_clear_sweep();
    test_byte_merge();
    test_halfword();
    test_addr_errors();
    test_flush();
    test_reset_run();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
